// File: rtl/gpio_blink_monitor.sv
// gpio_blink_monitor: counts low-high-low blinks on the management gpio pad and keeps a sticky pass/fail verdict.
// Optional checkbits observer is built when GPIO_BLINK_MON_CHECKBITS_EN is defined.
module gpio_blink_monitor #(
    parameter int BLINKS_REQ     = 10,
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int MIN_PULSE      = 2,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             gpio_in,
`ifdef GPIO_BLINK_MON_CHECKBITS_EN
    input  logic [15:0]      checkbits,
    output logic [15:0]      checkbits_last,
    output logic [7:0]       checkbits_changes,
`endif
    output logic [7:0]       blink_count,
    output logic [CNT_W-1:0] last_high_width,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic             short_pulse_err,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, ARM, WAIT_HIGH, IN_HIGH, PASS, FAIL} state_t;
    localparam logic [CNT_W-1:0] TC_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_PULSE);
    localparam logic [7:0]       REQ_LAST = 8'(BLINKS_REQ - 1);
    state_t state;
    logic s1, s2, s3;
    logic [CNT_W-1:0] tcnt, wcnt;
    logic rise, fall, active, wide, final_blink, tc_hit;
    assign rise        = s2 & ~s3;
    assign fall        = ~s2 & s3;
    assign active      = state inside {ARM, WAIT_HIGH, IN_HIGH};
    assign wide        = wcnt >= MIN_W;
    assign final_blink = (state == IN_HIGH) && fall && wide && (blink_count == REQ_LAST);
    assign tc_hit      = active && (tcnt == TC_LAST);
    assign done        = pass | fail;
    // synchronize the pad level and keep one extra stage for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= gpio_in;
            s2 <= s1;
            s3 <= s2;
        end
    end
    // blink FSM with timeout/width counters and registered verdict outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            tcnt            <= '0;
            wcnt            <= '0;
            blink_count     <= '0;
            last_high_width <= '0;
            pass            <= 1'b0;
            fail            <= 1'b0;
            timeout         <= 1'b0;
            short_pulse_err <= 1'b0;
        end else if (!enable) begin
            state           <= IDLE;
            tcnt            <= '0;
            wcnt            <= '0;
            blink_count     <= '0;
            last_high_width <= '0;
            pass            <= 1'b0;
            fail            <= 1'b0;
            timeout         <= 1'b0;
            short_pulse_err <= 1'b0;
        end else begin
            tcnt <= (state == IDLE) ? '0 : active ? tcnt + 1'b1 : tcnt;
            case (state)
                IDLE:      state <= ARM;
                ARM:       if (!s2) state <= WAIT_HIGH;
                WAIT_HIGH: if (rise) begin
                    wcnt  <= CNT_W'(1);
                    state <= IN_HIGH;
                end
                IN_HIGH: begin
                    if (s2 && !(&wcnt)) wcnt <= wcnt + 1'b1;
                    if (fall) begin
                        last_high_width <= wcnt;
                        if (wide) begin
                            blink_count <= blink_count + 1'b1;
                            state       <= final_blink ? PASS : WAIT_HIGH;
                            pass        <= final_blink;
                        end else begin
                            short_pulse_err <= 1'b1;
                            fail            <= 1'b1;
                            state           <= FAIL;
                        end
                    end
                end
                default: ;
            endcase
            // a final valid blink landing on the terminal count wins over the timeout
            if (tc_hit && !final_blink) begin
                timeout <= 1'b1;
                fail    <= 1'b1;
                state   <= FAIL;
            end
        end
    end
`ifdef GPIO_BLINK_MON_CHECKBITS_EN
    logic [15:0] cb1, cb2;
    // synchronize checkbits and count cycles where the synchronized value moves while armed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cb1               <= '0;
            cb2               <= '0;
            checkbits_last    <= '0;
            checkbits_changes <= '0;
        end else begin
            cb1               <= checkbits;
            cb2               <= cb1;
            checkbits_last    <= cb2;
            checkbits_changes <= (state == IDLE) ? '0 :
                                 (cb2 != checkbits_last && !(&checkbits_changes)) ? checkbits_changes + 1'b1 :
                                 checkbits_changes;
        end
    end
`endif
endmodule
